// File: rtl/uart_rx_frame_ctrl.sv
// Frames UART receiver bytes (SOF, LEN, payload, XOR checksum), buffers the payload and
// replays it to a valid/ready consumer; bad frames are dropped with a one-cycle error flag.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 8,
    parameter int         TIMEOUT = 5000
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       rx_en,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [2:0] err_pulse,
    output logic [2:0] state
);
    localparam int         IW    = $clog2(MAX_LEN + 1);
    localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         CW    = $clog2(TIMEOUT + 1);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_PAY  = 3'd2,
        S_CHK  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t        st;
    logic [7:0]    mem [MAX_LEN];
    logic [IW-1:0] len, idx, rd_idx, rd_nxt, idx_nxt;
    logic [7:0]    csum;
    logic [CW-1:0] gap;
    logic          wr_en;

    assign state   = st;
    assign rd_nxt  = rd_idx + IW'(1);
    assign idx_nxt = idx + IW'(1);
    assign wr_en   = (st == S_PAY) && rx_valid && !rx_err;

    // Payload storage is not reset; a dropped frame simply gets overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            st        <= S_IDLE;
            rx_en     <= 1'b1;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            pkt_data  <= '0;
            err_pulse <= '0;
            len       <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            csum      <= '0;
            gap       <= '0;
        end else begin
            err_pulse <= '0;
            case (st)
                S_IDLE: begin
                    gap <= '0;
                    if (rx_valid && !rx_err && rx_data == SOF) st <= S_LEN;
                end
                S_LEN, S_PAY, S_CHK: begin
                    if (rx_valid) begin
                        // A fresh byte always beats a coincident timeout.
                        gap <= '0;
                        if (rx_err) begin
                            st        <= S_IDLE;
                            err_pulse <= 3'b001;
                        end else begin
                            case (st)
                                S_LEN: begin
                                    if (rx_data == 8'd0 || rx_data > MAX_B) begin
                                        st        <= S_IDLE;
                                        err_pulse <= 3'b001;
                                    end else begin
                                        len  <= rx_data[IW-1:0];
                                        idx  <= '0;
                                        csum <= rx_data;
                                        st   <= S_PAY;
                                    end
                                end
                                S_PAY: begin
                                    csum <= csum ^ rx_data;
                                    idx  <= idx_nxt;
                                    if (idx_nxt == len) st <= S_CHK;
                                end
                                default: begin
                                    if (rx_data == csum) begin
                                        st        <= S_OUT;
                                        rx_en     <= 1'b0;
                                        pkt_valid <= 1'b1;
                                        pkt_data  <= mem[0];
                                        pkt_last  <= (len == IW'(1));
                                        rd_idx    <= '0;
                                    end else begin
                                        st        <= S_IDLE;
                                        err_pulse <= 3'b010;
                                    end
                                end
                            endcase
                        end
                    end else if (gap == CW'(TIMEOUT - 1)) begin
                        st        <= S_IDLE;
                        err_pulse <= 3'b100;
                        gap       <= '0;
                    end else begin
                        gap <= gap + CW'(1);
                    end
                end
                S_OUT: begin
                    if (pkt_ready) begin
                        if (pkt_last) begin
                            st        <= S_IDLE;
                            rx_en     <= 1'b1;
                            pkt_valid <= 1'b0;
                            pkt_last  <= 1'b0;
                        end else begin
                            rd_idx   <= rd_nxt;
                            pkt_data <= mem[rd_nxt[AW-1:0]];
                            pkt_last <= (rd_nxt == len - IW'(1));
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: a per-cycle vector table plus hand-written
// sequences for the inter-byte timeout and mid-frame / mid-output resets.
module tb_uart_rx_frame_ctrl;
    localparam int TO = 5000;

    logic       clk = 1'b0;
    logic       nRST;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_en;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic [2:0] err_pulse;
    logic [2:0] state;

    int n_vec = 0;
    int n_bad = 0;

    uart_rx_frame_ctrl #(.SOF(8'hA5), .MAX_LEN(8), .TIMEOUT(TO)) dut (
        .clk(clk), .nRST(nRST), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .rx_en(rx_en), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_last(pkt_last), .err_pulse(err_pulse), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       rdy;
        logic [2:0] st;
        logic       pv;
        logic [7:0] pd;
        logic       pl;
        logic [2:0] err;
        logic       en;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic e, input logic rdy,
                                input logic [2:0] st, input logic pv, input logic [7:0] pd,
                                input logic pl, input logic [2:0] err, input logic en);
        vec_t r;
        r.v = v; r.d = d; r.e = e; r.rdy = rdy;
        r.st = st; r.pv = pv; r.pd = pd; r.pl = pl; r.err = err; r.en = en;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b; rx_err = 1'b0;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0; pkt_ready = 1'b1;
        tick(); tick();
        chk("rst state", {5'd0, state}, 8'd0);
        chk("rst rx_en", {7'd0, rx_en}, 8'd1);
        chk("rst pkt_valid", {7'd0, pkt_valid}, 8'd0);
        chk("rst pkt_last", {7'd0, pkt_last}, 8'd0);
        chk("rst pkt_data", pkt_data, 8'd0);
        chk("rst err", {5'd0, err_pulse}, 8'd0);
        nRST = 1'b1;

        // good frame, consumer always ready
        add(1, 8'hA5, 0, 1, 1, 0, 0, 0, 3'b000, 1);
        add(1, 8'h02, 0, 1, 2, 0, 0, 0, 3'b000, 1);
        add(1, 8'h11, 0, 1, 2, 0, 0, 0, 3'b000, 1);
        add(1, 8'h22, 0, 1, 3, 0, 0, 0, 3'b000, 1);
        add(1, 8'h31, 0, 1, 4, 1, 8'h11, 0, 3'b000, 0);
        add(0, 8'h00, 0, 1, 4, 1, 8'h22, 1, 3'b000, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 3'b000, 1);
        // checksum mismatch
        add(1, 8'hA5, 0, 1, 1, 0, 0, 0, 3'b000, 1);
        add(1, 8'h02, 0, 1, 2, 0, 0, 0, 3'b000, 1);
        add(1, 8'h11, 0, 1, 2, 0, 0, 0, 3'b000, 1);
        add(1, 8'h22, 0, 1, 3, 0, 0, 0, 3'b000, 1);
        add(1, 8'h30, 0, 1, 0, 0, 0, 0, 3'b010, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 3'b000, 1);
        // length 0 and length MAX_LEN+1
        add(1, 8'hA5, 0, 1, 1, 0, 0, 0, 3'b000, 1);
        add(1, 8'h00, 0, 1, 0, 0, 0, 0, 3'b001, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 3'b000, 1);
        add(1, 8'hA5, 0, 1, 1, 0, 0, 0, 3'b000, 1);
        add(1, 8'h09, 0, 1, 0, 0, 0, 0, 3'b001, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 3'b000, 1);
        // idle ignores non-SOF and errored SOF; framing error mid-payload
        add(1, 8'h5A, 0, 1, 0, 0, 0, 0, 3'b000, 1);
        add(1, 8'hA5, 1, 1, 0, 0, 0, 0, 3'b000, 1);
        add(1, 8'hA5, 0, 1, 1, 0, 0, 0, 3'b000, 1);
        add(1, 8'h02, 0, 1, 2, 0, 0, 0, 3'b000, 1);
        add(1, 8'h11, 1, 1, 0, 0, 0, 0, 3'b001, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 3'b000, 1);
        // back-pressure: output held, receiver disabled, injected bytes ignored
        add(1, 8'hA5, 0, 0, 1, 0, 0, 0, 3'b000, 1);
        add(1, 8'h02, 0, 0, 2, 0, 0, 0, 3'b000, 1);
        add(1, 8'hAB, 0, 0, 2, 0, 0, 0, 3'b000, 1);
        add(1, 8'hCD, 0, 0, 3, 0, 0, 0, 3'b000, 1);
        add(1, 8'h64, 0, 0, 4, 1, 8'hAB, 0, 3'b000, 0);
        for (int k = 0; k < 10; k++)
            add(1, (k % 2 == 0) ? 8'hA5 : 8'h13, 0, 0, 4, 1, 8'hAB, 0, 3'b000, 0);
        add(0, 8'h00, 0, 1, 4, 1, 8'hCD, 1, 3'b000, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 3'b000, 1);

        foreach (tbl[i]) begin
            rx_valid = tbl[i].v; rx_data = tbl[i].d; rx_err = tbl[i].e; pkt_ready = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d state", i), {5'd0, state}, {5'd0, tbl[i].st});
            chk($sformatf("v%0d pkt_valid", i), {7'd0, pkt_valid}, {7'd0, tbl[i].pv});
            chk($sformatf("v%0d pkt_last", i), {7'd0, pkt_last}, {7'd0, tbl[i].pl});
            chk($sformatf("v%0d err", i), {5'd0, err_pulse}, {5'd0, tbl[i].err});
            chk($sformatf("v%0d rx_en", i), {7'd0, rx_en}, {7'd0, tbl[i].en});
            if (tbl[i].pv) chk($sformatf("v%0d pkt_data", i), pkt_data, tbl[i].pd);
        end
        rx_valid = 1'b0; rx_err = 1'b0; pkt_ready = 1'b1;

        // inter-byte timeout, then a clean one-byte frame
        send(8'hA5); send(8'h03); send(8'h44);
        begin
            int k;
            k = 0;
            while (err_pulse == 3'b000 && k < TO + 20) begin
                tick();
                k++;
            end
            chk("timeout cycles", 8'(k == TO), 8'd1);
            chk("timeout err", {5'd0, err_pulse}, 8'b100);
            chk("timeout state", {5'd0, state}, 8'd0);
        end
        tick();
        chk("timeout err clr", {5'd0, err_pulse}, 8'd0);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h7E);
        chk("post-to pkt_valid", {7'd0, pkt_valid}, 8'd1);
        chk("post-to pkt_data", pkt_data, 8'h7F);
        chk("post-to pkt_last", {7'd0, pkt_last}, 8'd1);
        tick();
        chk("post-to idle", {5'd0, state}, 8'd0);

        // reset during PAYLOAD
        send(8'hA5); send(8'h03); send(8'h11);
        chk("pre-rst state", {5'd0, state}, 8'd2);
        nRST = 1'b0; tick(); nRST = 1'b1;
        chk("rst-pay state", {5'd0, state}, 8'd0);
        chk("rst-pay rx_en", {7'd0, rx_en}, 8'd1);
        chk("rst-pay err", {5'd0, err_pulse}, 8'd0);
        // reset during OUT
        pkt_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h7E);
        chk("pre-rst out", {5'd0, state}, 8'd4);
        nRST = 1'b0; tick(); nRST = 1'b1;
        chk("rst-out state", {5'd0, state}, 8'd0);
        chk("rst-out pkt_valid", {7'd0, pkt_valid}, 8'd0);
        chk("rst-out rx_en", {7'd0, rx_en}, 8'd1);
        chk("rst-out pkt_data", pkt_data, 8'd0);
        chk("rst-out err", {5'd0, err_pulse}, 8'd0);
        pkt_ready = 1'b1;
        send(8'hA5); send(8'h02); send(8'h3C); send(8'hC3); send(8'hFD);
        chk("rec pkt_valid", {7'd0, pkt_valid}, 8'd1);
        chk("rec beat0", pkt_data, 8'h3C);
        chk("rec last0", {7'd0, pkt_last}, 8'd0);
        tick();
        chk("rec beat1", pkt_data, 8'hC3);
        chk("rec last1", {7'd0, pkt_last}, 8'd1);
        tick();
        chk("rec idle", {5'd0, state}, 8'd0);
        chk("rec pkt_valid off", {7'd0, pkt_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter SOF, default 8'hA5, start-of-frame byte value.
REQ-002 Parameter MAX_LEN, default 8, maximum payload bytes per frame (1..15).
REQ-003 Parameter TIMEOUT, default 5000, inter-byte gap limit in clk cycles.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 nRST  input  1  reset, synchronous, active-low.
REQ-006 rx_valid  input  1  one-cycle pulse: receiver has a byte on rx_data.
REQ-007 rx_data  input  8  received byte, qualified by rx_valid.
REQ-008 rx_err  input  1  receiver framing error, qualified by rx_valid.
REQ-009 rx_en  output  1  receiver enable; receiver holds off while low.
REQ-010 pkt_data  output  8  payload byte to consumer.
REQ-011 pkt_valid  output  1  pkt_data valid.
REQ-012 pkt_ready  input  1  consumer accepts beat when pkt_valid && pkt_ready.
REQ-013 pkt_last  output  1  high with final payload beat.
REQ-014 err_pulse  output  3  one-cycle flags {timeout, checksum, frame/length}.
REQ-015 state  output  3  current FSM state encoding.

Function
REQ-016 Frame format SHALL be SOF, LEN, LEN payload bytes, CHK; CHK = XOR of LEN and all payload bytes.
REQ-017 FSM states SHALL be IDLE=0, LEN=1, PAYLOAD=2, CHK=3, OUT=4.
REQ-018 IDLE: rx_valid with rx_data==SOF and !rx_err -> LEN; any other byte ignored, no error.
REQ-019 LEN: byte in 1..MAX_LEN -> store length, clear byte index, init checksum = LEN, go PAYLOAD; 0 or >MAX_LEN -> IDLE with err_pulse[0].
REQ-020 PAYLOAD: each rx_valid writes rx_data to buffer[index], XORs into checksum, increments index; index reaching LEN -> CHK.
REQ-021 CHK: rx_data==checksum -> OUT; mismatch -> IDLE with err_pulse[1], buffer discarded.
REQ-022 rx_err with rx_valid in LEN, PAYLOAD or CHK -> IDLE with err_pulse[0]; rx_err in IDLE ignored.
REQ-023 Gap counter SHALL clear on each rx_valid and on entry to LEN, count in LEN/PAYLOAD/CHK; reaching TIMEOUT -> IDLE with err_pulse[2].
REQ-024 Timeout and rx_valid in the same cycle: rx_valid wins, counter clears.
REQ-025 Buffer SHALL be MAX_LEN x 8 bits, index width ceil(log2(MAX_LEN+1)).
REQ-026 rx_en SHALL be 1 in IDLE, LEN, PAYLOAD, CHK and 0 in OUT; rx_valid in OUT ignored.
REQ-027 pkt_valid SHALL rise the cycle after the accepted CHK byte (1-cycle latency) and stay high throughout OUT.
REQ-028 pkt_data/pkt_last SHALL hold stable while pkt_valid && !pkt_ready.
REQ-029 Each accepted beat advances read index; pkt_last = (read index == LEN-1); accepted last beat -> IDLE, pkt_valid low next cycle.
REQ-030 err_pulse bits SHALL each be high exactly one cycle, coinciding with the return to IDLE.

Reset
REQ-031 nRST low at a clk edge SHALL force state=IDLE, rx_en=1, pkt_valid=0, pkt_last=0, pkt_data=0, err_pulse=0, counters and indices 0, from any state including mid-frame or mid-OUT.
REQ-032 Buffer contents need not be reset; partial frame SHALL be dropped without error pulse.

Verification
REQ-033 Bytes A5,02,11,22,31, pkt_ready=1 -> pkt_valid 1 cycle after 31; beats 11, 22(pkt_last=1); state returns 0; err_pulse stays 0.
REQ-034 Bytes A5,02,11,22,30 -> no pkt_valid; err_pulse=3'b010 one cycle; state 0.
REQ-035 Bytes A5,00 and separately A5,09 (MAX_LEN=8) -> err_pulse=3'b001 each; no output.
REQ-036 A5,03,44 then silence TIMEOUT cycles -> err_pulse=3'b100; following valid frame A5,01,7F,7E delivers 7F with pkt_last=1.
REQ-037 Valid frame with pkt_ready held 0 for 10 cycles -> pkt_data stable at first byte, rx_en=0, bytes injected meanwhile ignored.
REQ-038 nRST low one cycle during PAYLOAD and again during OUT -> next cycle state=0, pkt_valid=0, rx_en=1; a following valid frame is received correctly.
